// File: rtl/mac_host_ctrl.sv
// Host-side controller for a pin-level 8x8 multiply-accumulate block: sequences
// operand strobes, keeps a shadow accumulator and reads the MAC result back for comparison.
module mac_host_ctrl #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    input  logic             op_clear,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [ACC_W-1:0] rd_data,
    output logic             rd_mismatch,
    output logic [7:0]       mac_ui_in,
    output logic [7:0]       mac_uio_in,
    input  logic [7:0]       mac_uo_out
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLR     = 3'd1;
    localparam logic [2:0] ST_SEND_A  = 3'd2;
    localparam logic [2:0] ST_SEND_B  = 3'd3;
    localparam logic [2:0] ST_RD_SEL0 = 3'd4;
    localparam logic [2:0] ST_RD_CAP0 = 3'd5;
    localparam logic [2:0] ST_RD_CAP1 = 3'd6;

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [7:0]       a_r;
    logic [7:0]       b_r;
    logic             clr_r;
    logic [7:0]       lo_r;
    logic [ACC_W-1:0] shadow_r;
    logic [ACC_W-1:0] rd_data_r;
    logic             rd_valid_r;
    logic             rd_mismatch_r;
    logic             accept_s;
    logic [ACC_W-1:0] prod_s;
    logic [ACC_W-1:0] captured_s;

    // op_ready follows state directly, so it also reads 1 during reset when no read is pending
    assign op_ready   = (state_r == ST_IDLE) && !rd_req;
    assign accept_s   = op_valid && op_ready;
    assign prod_s     = ACC_W'(a_r) * ACC_W'(b_r);
    assign captured_s = {mac_uo_out, lo_r};

    assign rd_valid    = rd_valid_r;
    assign rd_data     = rd_data_r;
    assign rd_mismatch = rd_mismatch_r;

    // Next-state logic; a pending read wins over an offered operand pair
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_req) begin
                    state_nxt_s = ST_RD_SEL0;
                end else if (op_valid) begin
                    state_nxt_s = op_clear ? ST_CLR : ST_SEND_A;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLR:     state_nxt_s = ST_SEND_A;
            ST_SEND_A:  state_nxt_s = ST_SEND_B;
            ST_SEND_B:  state_nxt_s = ST_IDLE;
            ST_RD_SEL0: state_nxt_s = ST_RD_CAP0;
            ST_RD_CAP0: state_nxt_s = ST_RD_CAP1;
            ST_RD_CAP1: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // MAC pin decode from state and registered operands only, so reset drops strobes at once
    always_comb begin
        mac_ui_in  = 8'h00;
        mac_uio_in = 8'h00;
        case (state_r)
            ST_CLR: begin
                mac_ui_in  = 8'h00;
                mac_uio_in = {5'b00000, clr_r, 2'b00};
            end
            ST_SEND_A: begin
                mac_ui_in  = a_r;
                mac_uio_in = 8'h01;
            end
            ST_SEND_B: begin
                mac_ui_in  = b_r;
                mac_uio_in = 8'h02;
            end
            ST_RD_CAP0,
            ST_RD_CAP1: begin
                mac_ui_in  = 8'h00;
                mac_uio_in = 8'h08;
            end
            default: begin
                mac_ui_in  = 8'h00;
                mac_uio_in = 8'h00;
            end
        endcase
    end

    // State, operand capture, shadow accumulator and read-back registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            a_r           <= 8'h00;
            b_r           <= 8'h00;
            clr_r         <= 1'b0;
            lo_r          <= 8'h00;
            shadow_r      <= '0;
            rd_data_r     <= '0;
            rd_valid_r    <= 1'b0;
            rd_mismatch_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rd_valid_r <= (state_r == ST_RD_CAP1);
            if (accept_s) begin
                a_r   <= op_a;
                b_r   <= op_b;
                clr_r <= op_clear;
            end
            if (state_r == ST_CLR) begin
                shadow_r <= '0;
            end else if (state_r == ST_SEND_B) begin
                shadow_r <= shadow_r + prod_s;
            end
            // uo_out lags the byte select by one cycle: low byte is visible in CAP0, high in CAP1
            if (state_r == ST_RD_CAP0) begin
                lo_r <= mac_uo_out;
            end
            if (state_r == ST_RD_CAP1) begin
                rd_data_r     <= captured_s;
                rd_mismatch_r <= (captured_s != shadow_r);
            end
        end
    end

endmodule

// File: tb/tb_mac_host_ctrl.sv
// Self-checking bench for mac_host_ctrl with a behavioural pin-level MAC model
// and a scoreboard of expected read-back results.
module tb_mac_host_ctrl;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_clear;
    logic        rd_req;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_mismatch;
    logic [7:0]  mac_ui_in;
    logic [7:0]  mac_uio_in;
    logic [7:0]  mac_uo_out;

    int errors;
    int checks;

    // Bench-side reference of what the MAC accumulator should hold
    logic [15:0] exp_acc;
    logic [16:0] sb_q[$];

    // Behavioural MAC state
    logic [15:0] m_acc;
    logic [7:0]  m_a;
    logic        corrupt_hi;

    mac_host_ctrl #(.ACC_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_clear    (op_clear),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_mismatch (rd_mismatch),
        .mac_ui_in   (mac_ui_in),
        .mac_uio_in  (mac_uio_in),
        .mac_uo_out  (mac_uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin-level MAC: strobes act on the edge, uo_out is the selected byte registered one cycle later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc      <= 16'h0000;
            m_a        <= 8'h00;
            mac_uo_out <= 8'h00;
        end else begin
            if (mac_uio_in[0]) m_a <= mac_ui_in;
            if (mac_uio_in[2]) m_acc <= 16'h0000;
            else if (mac_uio_in[1]) m_acc <= m_acc + 16'(m_a) * 16'(mac_ui_in);
            if (mac_uio_in[3]) mac_uo_out <= m_acc[15:8] | (corrupt_hi ? 8'h01 : 8'h00);
            else mac_uo_out <= m_acc[7:0];
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic clr);
        int n;
        op_valid = 1'b1; op_a = a; op_b = b; op_clear = clr;
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL op_accept_timeout: op_ready=%b required 1", op_ready);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        if (clr) exp_acc = 16'h0000;
        exp_acc = exp_acc + 16'(a) * 16'(b);
        if (clr) begin
            @(negedge clk);
            checks++;
            if (mac_uio_in !== 8'h04 || mac_ui_in !== 8'h00) begin
                errors++;
                $display("FAIL clr_strobe: uio=%h ui=%h required 04/00", mac_uio_in, mac_ui_in);
            end
        end
        @(negedge clk);
        checks++;
        if (mac_uio_in !== 8'h01 || mac_ui_in !== a) begin
            errors++;
            $display("FAIL a_strobe: uio=%h ui=%h required 01/%h", mac_uio_in, mac_ui_in, a);
        end
        @(negedge clk);
        checks++;
        if (mac_uio_in !== 8'h02 || mac_ui_in !== b) begin
            errors++;
            $display("FAIL b_strobe: uio=%h ui=%h required 02/%h", mac_uio_in, mac_ui_in, b);
        end
        @(negedge clk);
        checks++;
        if (mac_uio_in !== 8'h00 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL op_return_idle: uio=%h op_ready=%b required 00/1", mac_uio_in, op_ready);
        end
    endtask

    // Push expected {mismatch,data}; wait for rd_valid, pop and compare
    task automatic do_read(input logic corrupt);
        int n;
        logic [16:0] exp;
        logic [15:0] exp_data;
        exp_data = corrupt ? (exp_acc | 16'h0100) : exp_acc;
        sb_q.push_back({(exp_data != exp_acc), exp_data});
        rd_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_valid && n < 20);
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || n != 4) begin
            errors++;
            $display("FAIL rd_latency: rd_valid=%b negedges=%0d required 1/4", rd_valid, n);
        end
        exp = sb_q.pop_front();
        checks++;
        if (rd_data !== exp[15:0] || rd_mismatch !== exp[16]) begin
            errors++;
            $display("FAIL rd_result: data=%h mism=%b required %h/%b", rd_data, rd_mismatch, exp[15:0], exp[16]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== exp[15:0] || rd_mismatch !== exp[16]) begin
            errors++;
            $display("FAIL rd_hold: valid=%b data=%h mism=%b required 0/%h/%b", rd_valid, rd_data, rd_mismatch, exp[15:0], exp[16]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b0; op_a = 8'h00; op_b = 8'h00; op_clear = 1'b0;
        rd_req = 1'b0; corrupt_hi = 1'b0; exp_acc = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if (mac_ui_in !== 8'h00 || mac_uio_in !== 8'h00 || rd_valid !== 1'b0 ||
            rd_data !== 16'h0000 || rd_mismatch !== 1'b0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: ui=%h uio=%h v=%b d=%h m=%b rdy=%b required 00/00/0/0000/0/1",
                     mac_ui_in, mac_uio_in, rd_valid, rd_data, rd_mismatch, op_ready);
        end
        rd_req = 1'b1;
        #1;
        checks++;
        if (op_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_rdreq: op_ready=%b required 0", op_ready);
        end
        rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_op(8'd3, 8'd4, 1'b1);
        do_read(1'b0);
    endtask

    task automatic test_wrap();
        do_op(8'd0, 8'd0, 1'b1);
        do_op(8'd255, 8'd255, 1'b0);
        do_op(8'd255, 8'd255, 1'b0);
        checks++;
        if (exp_acc !== 16'hFC02) begin
            errors++;
            $display("FAIL wrap_model: acc=%h required FC02", exp_acc);
        end
        do_read(1'b0);
    endtask

    task automatic test_back_to_back();
        do_op(8'd17, 8'd9, 1'b0);
        do_op(8'd200, 8'd3, 1'b0);
        do_read(1'b0);
    endtask

    task automatic test_priority();
        int n;
        logic [16:0] exp;
        sb_q.push_back({1'b0, exp_acc});
        op_valid = 1'b1; op_a = 8'd6; op_b = 8'd7; op_clear = 1'b0;
        rd_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!rd_valid) begin
                checks++;
                if (op_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL prio_ready_low: op_ready=%b cycle=%0d required 0", op_ready, n);
                end
            end
        end while (!rd_valid && n < 20);
        rd_req = 1'b0;
        exp = sb_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp[15:0] || rd_mismatch !== exp[16]) begin
            errors++;
            $display("FAIL prio_read: v=%b data=%h m=%b required 1/%h/%b", rd_valid, rd_data, rd_mismatch, exp[15:0], exp[16]);
        end
        #1;
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_ready_after: op_ready=%b required 1", op_ready);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        exp_acc = exp_acc + 16'd42;
        @(negedge clk);
        checks++;
        if (mac_uio_in !== 8'h01 || mac_ui_in !== 8'd6) begin
            errors++;
            $display("FAIL prio_op_a: uio=%h ui=%h required 01/06", mac_uio_in, mac_ui_in);
        end
        repeat (2) @(negedge clk);
        do_read(1'b0);
    endtask

    task automatic test_corrupt();
        do_op(8'd2, 8'd5, 1'b1);
        corrupt_hi = 1'b1;
        do_read(1'b1);
        corrupt_hi = 1'b0;
    endtask

    task automatic test_reset_abort();
        op_valid = 1'b1; op_a = 8'd7; op_b = 8'd9; op_clear = 1'b0;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mac_uio_in !== 8'h01) begin
            errors++;
            $display("FAIL abort_in_send_a: uio=%h required 01", mac_uio_in);
        end
        #2;
        rst_n = 1'b0;
        exp_acc = 16'h0000;
        #1;
        checks++;
        if (mac_uio_in !== 8'h00 || mac_ui_in !== 8'h00) begin
            errors++;
            $display("FAIL abort_immediate: uio=%h ui=%h required 00/00", mac_uio_in, mac_ui_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mac_uio_in !== 8'h00) begin
                errors++;
                $display("FAIL abort_no_b: uio=%h cycle=%0d required 00", mac_uio_in, i);
            end
        end
        do_read(1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_priority();
        test_corrupt();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
